// File: rtl/fft_pkg.sv
// Shared types, widths and the saturation helper for the FFT result write-back stage.
package fft_pkg;

    localparam int unsigned ACC_W  = 18;
    localparam int unsigned OUT_W  = 16;
    localparam int unsigned SAMP_W = 12;

    typedef enum logic [1:0] {StIdle, StRun, StDone} wr_state_t;

    // A value fits in OUT_W bits only when its top ACC_W-OUT_W+1 bits all match the sign.
    function automatic logic [OUT_W-1:0] sat18to16(input logic [ACC_W-1:0] x);
        logic [ACC_W-OUT_W:0] top;
        top = x[ACC_W-1:OUT_W-1];
        if (top == '0 || top == '1) begin
            return x[OUT_W-1:0];
        end else if (x[ACC_W-1]) begin
            return {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            return {1'b0, {(OUT_W-1){1'b1}}};
        end
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Show-ahead synchronous FIFO: rdata always presents the head entry while not empty.
module result_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             wr_en, rd_en;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;
    assign rdata = mem[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/fft_result_writer.sv
// Saturates FFT accumulator results to 16-bit components, buffers them and streams them
// onto the AXI write channel in bursts of up to 2^N beats.
module fft_result_writer
    import fft_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SAMP_W-1:0] samp_number,
    input  logic [35:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [32:0]       AWDATA,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [N:0]        AWBURST,
    output logic              busy,
    output logic              done
);

    localparam logic [SAMP_W-1:0] MAX_BURST = SAMP_W'(1 << N);

    function automatic logic [N:0] clip_burst(input logic [SAMP_W-1:0] left);
        if (left >= MAX_BURST) begin
            return (N+1)'(MAX_BURST);
        end else begin
            return (N+1)'(left);
        end
    endfunction

    wr_state_t         state_q, state_d;
    logic [SAMP_W-1:0] in_left_q, in_left_d;
    logic [SAMP_W-1:0] out_left_q, out_left_d;
    logic [N:0]        burst_len_q, burst_len_d;
    logic [N:0]        beat_cnt_q, beat_cnt_d;

    logic        fifo_full, fifo_empty;
    logic [31:0] fifo_wdata, fifo_rdata;
    logic        push, pop, last_beat;

    assign fifo_wdata = {sat18to16(in_data[2*ACC_W-1:ACC_W]), sat18to16(in_data[ACC_W-1:0])};

    assign in_ready  = (state_q == StRun) & ~fifo_full & (in_left_q != '0);
    assign AWVALID   = (state_q == StRun) & ~fifo_empty;
    assign push      = in_valid & in_ready;
    assign pop       = AWVALID & AWREADY;
    assign last_beat = (beat_cnt_q == burst_len_q);
    assign AWDATA    = AWVALID ? {last_beat, fifo_rdata} : '0;
    assign AWBURST   = burst_len_q;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);

    result_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // burst_len is loaded ahead of each burst so AWBURST is already valid when AWVALID rises.
    always_comb begin
        state_d     = state_q;
        in_left_d   = in_left_q;
        out_left_d  = out_left_q;
        burst_len_d = burst_len_q;
        beat_cnt_d  = beat_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    in_left_d   = samp_number;
                    out_left_d  = samp_number;
                    burst_len_d = clip_burst(samp_number);
                    beat_cnt_d  = (N+1)'(1);
                    state_d     = (samp_number == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (push) in_left_d = in_left_q - SAMP_W'(1);
                if (pop) begin
                    out_left_d = out_left_q - SAMP_W'(1);
                    if (last_beat) begin
                        beat_cnt_d  = (N+1)'(1);
                        burst_len_d = clip_burst(out_left_q - SAMP_W'(1));
                    end else begin
                        beat_cnt_d = beat_cnt_q + (N+1)'(1);
                    end
                    if (out_left_q == SAMP_W'(1)) state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            in_left_q   <= '0;
            out_left_q  <= '0;
            burst_len_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            in_left_q   <= in_left_d;
            out_left_q  <= out_left_d;
            burst_len_q <= burst_len_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fft_result_writer.sv
// Directed bench for fft_result_writer (N=2, DEPTH=8) with hand-computed expectations.
module tb_fft_result_writer;

    logic        clk, rst, start, in_valid, in_ready, AWVALID, AWREADY, busy, done;
    logic [11:0] samp_number;
    logic [35:0] in_data;
    logic [32:0] AWDATA;
    logic [2:0]  AWBURST;

    int vecs = 0;
    int errs = 0;

    logic [35:0] in_vec[$];
    logic [32:0] cap_data[$];
    logic [2:0]  cap_burst[$];
    int accepts, accepts_stall, done_cnt, done_cyc, first_acc, first_aw, last_hs;
    bit aw_seen, held_change, inready_extra, timed_out, first_busy, first_inready;
    bit ready_end_stall;

    fft_result_writer #(
        .N     (2),
        .DEPTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .samp_number (samp_number),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .AWDATA      (AWDATA),
        .AWVALID     (AWVALID),
        .AWREADY     (AWREADY),
        .AWBURST     (AWBURST),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one frame: pulses start, feeds in_vec, records every handshake until idle again.
    task automatic run_frame(input int n, input int stall, input int mid_start,
                             input bit overfeed, input int abort_after);
        int  idx;
        bit  hs_in, hs_out, ended, holding;
        logic [32:0] held_data;
        logic [2:0]  held_burst;
        idx = 0; holding = 0; ended = 0;
        held_data = '0; held_burst = '0;
        cap_data.delete(); cap_burst.delete();
        accepts = 0; accepts_stall = 0; done_cnt = 0; done_cyc = -1;
        first_acc = -1; first_aw = -1; last_hs = -1;
        aw_seen = 0; held_change = 0; inready_extra = 0; timed_out = 1;
        first_busy = 0; first_inready = 0; ready_end_stall = 1;
        start = 1'b1; samp_number = 12'(n); in_valid = 1'b0; AWREADY = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            in_valid = overfeed || (idx < in_vec.size());
            in_data  = (idx < in_vec.size()) ? in_vec[idx] : 36'h0;
            AWREADY  = (c >= stall);
            start    = (c == mid_start);
            if (c == mid_start) samp_number = 12'd2;
            @(negedge clk);
            if (c == 0) begin
                first_busy    = busy;
                first_inready = in_ready;
            end
            hs_in  = in_valid && in_ready;
            hs_out = AWVALID && AWREADY;
            if (in_ready && accepts >= n) inready_extra = 1;
            if (hs_in) begin
                if (first_acc < 0) first_acc = c;
                accepts++;
                if (c < stall) accepts_stall++;
            end
            if (c == stall - 1) ready_end_stall = in_ready;
            if (AWVALID) aw_seen = 1;
            if (AWVALID && first_aw < 0) first_aw = c;
            if (AWVALID && !AWREADY) begin
                if (holding && (AWDATA !== held_data || AWBURST !== held_burst)) held_change = 1;
                holding = 1; held_data = AWDATA; held_burst = AWBURST;
            end else begin
                holding = 0;
            end
            if (hs_out) begin
                cap_data.push_back(AWDATA);
                cap_burst.push_back(AWBURST);
                last_hs = c;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            ended = (done_cyc >= 0) && !busy;
            @(posedge clk); #1;
            if (hs_in) idx++;
            if (ended || (abort_after > 0 && cap_data.size() == abort_after)) begin
                timed_out = 0;
                break;
            end
        end
        start = 1'b0; in_valid = 1'b0; AWREADY = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; samp_number = '0; in_data = '0;
        in_valid = 1'b0; AWREADY = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vecs++;
        if ({in_ready, AWVALID, AWDATA, AWBURST, busy, done} !== '0) begin
            errs++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h burst=%0d busy=%b done=%b want all 0",
                     in_ready, AWVALID, AWDATA, AWBURST, busy, done);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        vecs++;
        if ({in_ready, AWVALID, busy, done} !== 4'b0) begin
            errs++;
            $display("FAIL post_reset_idle: got rdy=%b vld=%b busy=%b done=%b want 0",
                     in_ready, AWVALID, busy, done);
        end
    endtask

    task automatic test_basic_frame();
        logic [32:0] exp_d[5];
        logic [2:0]  exp_b[5];
        exp_d = '{33'h0_0001_FFFF, 33'h0_0002_FFFE, 33'h0_0003_FFFD, 33'h1_0004_FFFC,
                  33'h1_0005_FFFB};
        exp_b = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd1};
        in_vec.delete();
        for (int k = 1; k <= 5; k++) in_vec.push_back({18'(k), 18'(-k)});
        run_frame(5, 0, -1, 0, 0);
        vecs++;
        if (timed_out || cap_data.size() != 5) begin
            errs++;
            $display("FAIL basic_beats: got %0d beats (timeout=%b) want 5", cap_data.size(), timed_out);
        end
        for (int i = 0; i < 5; i++) begin
            vecs++;
            if (i >= cap_data.size() || cap_data[i] !== exp_d[i] || cap_burst[i] !== exp_b[i]) begin
                errs++;
                if (i < cap_data.size())
                    $display("FAIL basic_beat%0d: got data=%h burst=%0d want data=%h burst=%0d",
                             i, cap_data[i], cap_burst[i], exp_d[i], exp_b[i]);
                else
                    $display("FAIL basic_beat%0d: got no beat want data=%h", i, exp_d[i]);
            end
        end
        vecs++;
        if (done_cnt != 1) begin
            errs++;
            $display("FAIL basic_done_pulses: got %0d want 1", done_cnt);
        end
        vecs++;
        if (first_busy !== 1'b1 || first_inready !== 1'b1) begin
            errs++;
            $display("FAIL basic_start_latency: got busy=%b in_ready=%b want 1 1",
                     first_busy, first_inready);
        end
        vecs++;
        if (first_aw != first_acc + 1) begin
            errs++;
            $display("FAIL basic_awvalid_latency: got accept@%0d awvalid@%0d want gap 1",
                     first_acc, first_aw);
        end
        vecs++;
        if (last_hs != first_aw + 4) begin
            errs++;
            $display("FAIL basic_throughput: got last beat@%0d want %0d", last_hs, first_aw + 4);
        end
        vecs++;
        if (done_cyc != last_hs + 1) begin
            errs++;
            $display("FAIL basic_done_latency: got done@%0d want %0d", done_cyc, last_hs + 1);
        end
    endtask

    task automatic test_saturation();
        logic [32:0] exp_d[3];
        exp_d = '{33'h0_7FFF_8000, 33'h0_0064_FFFD, 33'h1_FFFF_7FFF};
        in_vec.delete();
        in_vec.push_back({18'h1FFFF, 18'h20000});
        in_vec.push_back({18'd100, 18'h3FFFD});
        in_vec.push_back({18'h3FFFF, 18'h08000});
        run_frame(3, 0, -1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if (i >= cap_data.size() || cap_data[i] !== exp_d[i] || cap_burst[i] !== 3'd3) begin
                errs++;
                if (i < cap_data.size())
                    $display("FAIL sat_beat%0d: got data=%h burst=%0d want data=%h burst=3",
                             i, cap_data[i], cap_burst[i], exp_d[i]);
                else
                    $display("FAIL sat_beat%0d: got no beat want data=%h", i, exp_d[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [32:0] exp_v;
        in_vec.delete();
        for (int k = 0; k < 8; k++) in_vec.push_back({18'(k + 10), 18'(k + 20)});
        run_frame(8, 20, -1, 0, 0);
        vecs++;
        if (accepts_stall != 8 || ready_end_stall !== 1'b0) begin
            errs++;
            $display("FAIL bp_fill: got %0d accepts in_ready=%b want 8 accepts in_ready=0",
                     accepts_stall, ready_end_stall);
        end
        vecs++;
        if (held_change) begin
            errs++;
            $display("FAIL bp_hold: got AWDATA/AWBURST change while stalled want stable");
        end
        vecs++;
        if (cap_data.size() != 8) begin
            errs++;
            $display("FAIL bp_count: got %0d beats want 8", cap_data.size());
        end
        for (int k = 0; k < 8; k++) begin
            exp_v = {(k == 3 || k == 7) ? 1'b1 : 1'b0, 16'(k + 10), 16'(k + 20)};
            vecs++;
            if (k >= cap_data.size() || cap_data[k] !== exp_v || cap_burst[k] !== 3'd4) begin
                errs++;
                if (k < cap_data.size())
                    $display("FAIL bp_beat%0d: got data=%h burst=%0d want data=%h burst=4",
                             k, cap_data[k], cap_burst[k], exp_v);
                else
                    $display("FAIL bp_beat%0d: got no beat want data=%h", k, exp_v);
            end
        end
    endtask

    task automatic test_overfeed();
        in_vec.delete();
        for (int k = 1; k <= 6; k++) in_vec.push_back({18'(k), 18'd0});
        run_frame(3, 0, -1, 1, 0);
        vecs++;
        if (accepts != 3 || inready_extra) begin
            errs++;
            $display("FAIL overfeed_inputs: got %0d accepts extra_ready=%b want 3 and 0",
                     accepts, inready_extra);
        end
        vecs++;
        if (cap_data.size() != 3 || timed_out) begin
            errs++;
            $display("FAIL overfeed_beats: got %0d beats want 3", cap_data.size());
        end
        vecs++;
        if (cap_data.size() == 3 && cap_data[2] !== 33'h1_0003_0000) begin
            errs++;
            $display("FAIL overfeed_last: got %h want 100030000", cap_data[2]);
        end
    endtask

    task automatic test_zero_length();
        in_vec.delete();
        run_frame(0, 0, -1, 0, 0);
        vecs++;
        if (timed_out || done_cyc < 0 || done_cyc > 1 || done_cnt != 1) begin
            errs++;
            $display("FAIL zero_done: got done@%0d count=%0d want one pulse within 2 cycles",
                     done_cyc, done_cnt);
        end
        vecs++;
        if (aw_seen) begin
            errs++;
            $display("FAIL zero_awvalid: got AWVALID=1 want never");
        end
    endtask

    task automatic test_start_ignored();
        logic [2:0] exp_b[6];
        exp_b = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd2, 3'd2};
        in_vec.delete();
        for (int k = 1; k <= 6; k++) in_vec.push_back({18'(k), 18'd0});
        run_frame(6, 0, 2, 0, 0);
        vecs++;
        if (cap_data.size() != 6 || done_cnt != 1) begin
            errs++;
            $display("FAIL restart_beats: got %0d beats %0d dones want 6 and 1",
                     cap_data.size(), done_cnt);
        end
        for (int i = 0; i < 6; i++) begin
            vecs++;
            if (i >= cap_burst.size() || cap_burst[i] !== exp_b[i]
                || cap_data[i][32] !== ((i == 3 || i == 5) ? 1'b1 : 1'b0)) begin
                errs++;
                if (i < cap_burst.size())
                    $display("FAIL restart_beat%0d: got burst=%0d last=%b want burst=%0d",
                             i, cap_burst[i], cap_data[i][32], exp_b[i]);
                else
                    $display("FAIL restart_beat%0d: got no beat want burst=%0d", i, exp_b[i]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        in_vec.delete();
        for (int k = 1; k <= 4; k++) in_vec.push_back({18'(k), 18'(k)});
        run_frame(4, 0, -1, 0, 2);
        rst = 1'b1;
        #1;
        vecs++;
        if (timed_out || {in_ready, AWVALID, AWDATA, AWBURST, busy, done} !== '0) begin
            errs++;
            $display("FAIL midreset_outputs: got rdy=%b vld=%b data=%h burst=%0d busy=%b want all 0",
                     in_ready, AWVALID, AWDATA, AWBURST, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        vecs++;
        if (AWVALID !== 1'b0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL midreset_empty: got AWVALID=%b busy=%b want 0 0", AWVALID, busy);
        end
        in_vec.delete();
        in_vec.push_back({18'd7, 18'd8});
        in_vec.push_back({18'd9, 18'd10});
        run_frame(2, 0, -1, 0, 0);
        vecs++;
        if (cap_data.size() != 2 || timed_out) begin
            errs++;
            $display("FAIL midreset_frame: got %0d beats want 2", cap_data.size());
        end else begin
            vecs++;
            if (cap_data[0] !== 33'h0_0007_0008 || cap_data[1] !== 33'h1_0009_000A
                || cap_burst[0] !== 3'd2 || cap_burst[1] !== 3'd2) begin
                errs++;
                $display("FAIL midreset_burst: got %h/%0d %h/%0d want 000070008/2 10009000a/2",
                         cap_data[0], cap_burst[0], cap_data[1], cap_burst[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_saturation();
        test_backpressure();
        test_overfeed();
        test_zero_length();
        test_start_ignored();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
